// File: rtl/scan_mux.sv
// scan_mux -- registered N-way channel multiplexer with manual select and auto-scan.
//
// The block picks one WIDTH-bit slice out of a packed channel bus and registers it.
// Mode 0 selects the channel from SELECT. Mode 1 scans through the channels, staying
// on each one for DWELL cycles. Mode 1 with Hold high freezes the scan. M and Chan
// load together on the same edge, so M always shows the data of the channel in Chan.
//
// Ports:
//   Clock   in   1               system clock, rising edge
//   Reset   in   1               asynchronous, active-high reset
//   Data    in   CHANNELS*WIDTH  packed inputs, channel k at [k*WIDTH +: WIDTH]
//   SELECT  in   SEL_W           manual channel select
//   Mode    in   1               0 = manual, 1 = auto-scan
//   Hold    in   1               freezes the scan advance while Mode = 1
//   M       out  WIDTH           registered data of channel Chan
//   Chan    out  SEL_W           channel index that M reflects
//   Valid   out  1               high from the first edge after reset onward
//   Wrap    out  1               one-cycle pulse when the scan returns to channel 0
//   SelErr  out  1               one-cycle pulse when an out-of-range SELECT is seen in manual mode
//
// state    | meaning
// ST_MAN   | Mode=0: Chan follows SELECT when it is in range, dwell count held at 0
// ST_SCAN  | Mode=1, Hold=0: dwell count runs and Chan advances every DWELL cycles
// ST_PAUSE | Mode=1, Hold=1: dwell count and Chan frozen, M still reloads

module scan_mux #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] Data,
    input  logic [SEL_W-1:0]          SELECT,
    input  logic                      Mode,
    input  logic                      Hold,
    output logic [WIDTH-1:0]          M,
    output logic [SEL_W-1:0]          Chan,
    output logic                      Valid,
    output logic                      Wrap,
    output logic                      SelErr
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        ST_MAN   = 2'd0,
        ST_SCAN  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  chan_q, chan_d;
    logic [DW_W-1:0]   dwell_q, dwell_d, dwell_cur;
    logic [WIDTH-1:0]  m_q, m_d;
    logic              valid_q;
    logic              wrap_q, wrap_d;
    logic              sel_err_q, sel_err_d;
    logic              last_chan, dwell_done;

    // The mode inputs decide the state again on every edge, and the state they give
    // controls that edge's update. A switch to manual therefore takes SELECT at once.
    always_comb begin
        state_d = ST_MAN;
        if (Mode) begin
            state_d = Hold ? ST_PAUSE : ST_SCAN;
        end
    end

    always_comb begin
        chan_d    = chan_q;
        dwell_d   = dwell_q;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;
        // A scan that starts out of manual mode always begins with a fresh dwell count.
        dwell_cur  = (state_q == ST_MAN) ? '0 : dwell_q;
        last_chan  = (int'(chan_q) == CHANNELS - 1);
        dwell_done = (int'(dwell_cur) == DWELL - 1);

        case (state_d)
            ST_MAN: begin
                dwell_d = '0;
                if (int'(SELECT) < CHANNELS) begin
                    chan_d = SELECT;
                end else begin
                    sel_err_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (dwell_done) begin
                    dwell_d = '0;
                    if (last_chan) begin
                        chan_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        chan_d = chan_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_cur + 1'b1;
                end
            end
            ST_PAUSE: begin
                dwell_d = dwell_cur;
            end
            default: begin
                dwell_d = '0;
            end
        endcase

        // M is loaded from the channel that Chan will hold after this edge.
        m_d = Data[int'(chan_d) * WIDTH +: WIDTH];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_MAN;
            chan_q    <= '0;
            dwell_q   <= '0;
            m_q       <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            dwell_q   <= dwell_d;
            m_q       <= m_d;
            valid_q   <= 1'b1;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign M      = m_q;
    assign Chan   = chan_q;
    assign Valid  = valid_q;
    assign Wrap   = wrap_q;
    assign SelErr = sel_err_q;

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;

    // 8-channel instance (WIDTH=3, DWELL=4)
    logic [23:0] data_a;
    logic [2:0]  sel_a;
    logic        mode_a, hold_a;
    logic [2:0]  m_a, chan_a;
    logic        valid_a, wrap_a, selerr_a;

    // 5-channel instance for out-of-range select checks
    logic [14:0] data_b;
    logic [2:0]  sel_b;
    logic        mode_b, hold_b;
    logic [2:0]  m_b, chan_b;
    logic        valid_b, wrap_b, selerr_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    scan_mux #(.WIDTH(3), .CHANNELS(8), .SEL_W(3), .DWELL(4)) dut_a (
        .Clock(Clock), .Reset(Reset), .Data(data_a), .SELECT(sel_a),
        .Mode(mode_a), .Hold(hold_a), .M(m_a), .Chan(chan_a),
        .Valid(valid_a), .Wrap(wrap_a), .SelErr(selerr_a)
    );

    scan_mux #(.WIDTH(3), .CHANNELS(5), .SEL_W(3), .DWELL(4)) dut_b (
        .Clock(Clock), .Reset(Reset), .Data(data_b), .SELECT(sel_b),
        .Mode(mode_b), .Hold(hold_b), .M(m_b), .Chan(chan_b),
        .Valid(valid_b), .Wrap(wrap_b), .SelErr(selerr_b)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_default_data();
        for (int k = 0; k < 8; k++) data_a[k*3 +: 3] = 3'(k);
        for (int k = 0; k < 5; k++) data_b[k*3 +: 3] = 3'(k);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        load_default_data();
        sel_a = 3'd5; mode_a = 1'b0; hold_a = 1'b0;
        sel_b = 3'd0; mode_b = 1'b0; hold_b = 1'b0;
        #12;
        n_checks++;
        if ({m_a, chan_a, valid_a, wrap_a, selerr_a} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got m=%0d chan=%0d valid=%0b wrap=%0b selerr=%0b, want all 0",
                     m_a, chan_a, valid_a, wrap_a, selerr_a);
        end
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({m_a, chan_a, valid_a} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_before_edge: got m=%0d chan=%0d valid=%0b, want 0 0 0", m_a, chan_a, valid_a);
        end
        tick();
        n_checks++;
        if (valid_a !== 1'b1 || chan_a !== 3'd5 || m_a !== 3'd5) begin
            n_fail++;
            $display("FAIL reset_first_edge: got valid=%0b chan=%0d m=%0d, want 1 5 5", valid_a, chan_a, m_a);
        end
    endtask

    task automatic test_manual();
        for (int i = 0; i < 8; i++) begin
            sel_a = 3'(i);
            tick();
            n_checks++;
            if (chan_a !== 3'(i) || m_a !== 3'(i) || selerr_a !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_step%0d: got chan=%0d m=%0d selerr=%0b, want %0d %0d 0",
                         i, chan_a, m_a, selerr_a, i, i);
            end
        end
        sel_a = 3'd3;
        tick();
        data_a[9 +: 3] = 3'd6;
        tick();
        n_checks++;
        if (m_a !== 3'd6 || chan_a !== 3'd3) begin
            n_fail++;
            $display("FAIL manual_data_track: got m=%0d chan=%0d, want 6 3", m_a, chan_a);
        end
        load_default_data();
    endtask

    task automatic test_sel_err();
        sel_b = 3'd2;
        tick();
        n_checks++;
        if (chan_b !== 3'd2 || m_b !== 3'd2) begin
            n_fail++;
            $display("FAIL selerr_setup: got chan=%0d m=%0d, want 2 2", chan_b, m_b);
        end
        sel_b = 3'd6;
        tick();
        n_checks++;
        if (chan_b !== 3'd2 || m_b !== 3'd2 || selerr_b !== 1'b1) begin
            n_fail++;
            $display("FAIL selerr_pulse: got chan=%0d m=%0d selerr=%0b, want 2 2 1", chan_b, m_b, selerr_b);
        end
        sel_b = 3'd4;
        tick();
        n_checks++;
        if (chan_b !== 3'd4 || m_b !== 3'd4 || selerr_b !== 1'b0) begin
            n_fail++;
            $display("FAIL selerr_clear: got chan=%0d m=%0d selerr=%0b, want 4 4 0", chan_b, m_b, selerr_b);
        end
    endtask

    task automatic test_scan_wrap();
        // expected Chan after each SCAN edge, starting from Chan=6 with a fresh dwell count
        logic [2:0] exp_chan [12] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7,
                                      3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        sel_a = 3'd6;
        tick();
        mode_a = 1'b1; hold_a = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            n_checks++;
            if (chan_a !== exp_chan[e] || m_a !== exp_chan[e] || wrap_a !== (e == 7) || selerr_a !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_edge%0d: got chan=%0d m=%0d wrap=%0b selerr=%0b, want chan=m=%0d wrap=%0b selerr=0",
                         e + 1, chan_a, m_a, wrap_a, selerr_a, exp_chan[e], (e == 7));
            end
        end
    endtask

    task automatic test_pause();
        mode_a = 1'b0; sel_a = 3'd3;
        tick();
        mode_a = 1'b1; hold_a = 1'b0;
        tick();
        tick();
        hold_a = 1'b1;
        for (int e = 0; e < 10; e++) begin
            if (e == 4) data_a[9 +: 3] = 3'd5;
            tick();
            n_checks++;
            if (chan_a !== 3'd3 || m_a !== ((e >= 4) ? 3'd5 : 3'd3) || wrap_a !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_edge%0d: got chan=%0d m=%0d wrap=%0b, want 3 %0d 0",
                         e + 1, chan_a, m_a, wrap_a, (e >= 4) ? 5 : 3);
            end
        end
        load_default_data();
        hold_a = 1'b0;
        tick();
        n_checks++;
        if (chan_a !== 3'd3) begin
            n_fail++;
            $display("FAIL resume_edge1: got chan=%0d, want 3", chan_a);
        end
        tick();
        n_checks++;
        if (chan_a !== 3'd4 || m_a !== 3'd4) begin
            n_fail++;
            $display("FAIL resume_edge2: got chan=%0d m=%0d, want 4 4", chan_a, m_a);
        end
    endtask

    task automatic test_mode_switch();
        // leave the scan mid-dwell: manual must take SELECT at once
        tick();
        mode_a = 1'b0; sel_a = 3'd2;
        tick();
        n_checks++;
        if (chan_a !== 3'd2 || m_a !== 3'd2) begin
            n_fail++;
            $display("FAIL scan_to_man: got chan=%0d m=%0d, want 2 2", chan_a, m_a);
        end
        mode_a = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            n_checks++;
            if (chan_a !== ((e == 3) ? 3'd3 : 3'd2)) begin
                n_fail++;
                $display("FAIL man_to_scan_edge%0d: got chan=%0d, want %0d", e + 1, chan_a, (e == 3) ? 3 : 2);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        mode_a = 1'b0; sel_a = 3'd5;
        tick();
        mode_a = 1'b1;
        tick();
        tick();
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({m_a, chan_a, valid_a, wrap_a, selerr_a} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_async: got m=%0d chan=%0d valid=%0b wrap=%0b selerr=%0b, want all 0",
                     m_a, chan_a, valid_a, wrap_a, selerr_a);
        end
        @(negedge Clock);
        Reset = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            n_checks++;
            if (chan_a !== ((e == 3) ? 3'd1 : 3'd0) || valid_a !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_edge%0d: got chan=%0d valid=%0b, want %0d 1",
                         e + 1, chan_a, valid_a, (e == 3) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_sel_err();
        test_scan_wrap();
        test_pause();
        test_mode_switch();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
